// File: rtl/riscv_lsu.sv
// Load-store unit: takes one core load/store at a time, issues a registered word-aligned
// memory request, waits for mem_ready_i (bounded by TIMEOUT_CYCLES), then returns extended load data.
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        lsu_err_o,
  output logic [1:0]  lsu_err_code_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_ALIGN = 2'd1;
  localparam logic [1:0] CODE_SIZE  = 2'd2;
  localparam logic [1:0] CODE_TMO   = 2'd3;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  code_q, code_d;
  logic [31:0] rd_q, rd_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_req;
  logic [31:0] wd_req;

  function automatic logic [31:0] load_extend(input logic [2:0]  size,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      3'd0:    r = {{24{b[7]}}, b};
      3'd1:    r = {{16{h[15]}}, h};
      3'd4:    r = {24'd0, b};
      3'd5:    r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Request decode: legality, alignment, byte lanes and replicated store data
  always_comb begin
    illegal    = core_we_i ? (core_size_i > 3'd2)
                           : (core_size_i == 3'd3 || core_size_i == 3'd6 || core_size_i == 3'd7);
    misaligned = 1'b0;
    be_req     = 4'b1111;
    wd_req     = core_wd_i;
    case (core_size_i[1:0])
      2'd0: begin
        be_req = 4'b0001 << core_addr_i[1:0];
        wd_req = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        misaligned = core_addr_i[0];
        be_req     = 4'b0011 << {core_addr_i[1], 1'b0};
        wd_req     = {2{core_wd_i[15:0]}};
      end
      default: begin
        misaligned = |core_addr_i[1:0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    rd_d    = rd_q;
    req_d   = req_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    size_d  = size_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (core_req_i) begin
          if (illegal || misaligned) begin
            code_d  = illegal ? CODE_SIZE : CODE_ALIGN;
            rd_d    = '0;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = core_we_i;
            be_d    = be_req;
            addr_d  = {core_addr_i[31:2], 2'b00};
            wd_d    = wd_req;
            size_d  = core_size_i;
            off_d   = core_addr_i[1:0];
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // Completion takes priority over a timeout landing in the same cycle
        if (mem_ready_i) begin
          rd_d    = we_q ? '0 : load_extend(size_q, off_q, mem_rd_i);
          req_d   = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
            req_d   = 1'b0;
            code_d  = CODE_TMO;
            rd_d    = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        code_d  = CODE_NONE;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      code_q  <= CODE_NONE;
      rd_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      size_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      rd_q    <= rd_d;
      req_q   <= req_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  assign core_stall_o   = core_req_i && (state_q != DONE);
  assign core_rd_o      = rd_q;
  assign lsu_err_o      = (state_q == DONE) && (code_q != CODE_NONE);
  assign lsu_err_code_o = code_q;
  assign mem_req_o      = req_q;
  assign mem_we_o       = we_q;
  assign mem_be_o       = be_q;
  assign mem_addr_o     = addr_q;
  assign mem_wd_o       = wd_q;

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
- Load-store unit between the single-cycle RISC-V core's data port and the data memory.
- Takes one load/store request from the core and holds the core stalled while the request is in flight.
- Issues a registered, word-aligned request to memory, waits for the memory ready handshake, then aligns and sign- or zero-extends load data.
- Releases the core for exactly one cycle per completed access, and flags misaligned, illegal-size and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, max BUSY cycles without mem_ready_i before the access is aborted (1..65535)

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous reset, active-high
core_req_i  input  1  core requests a memory access (held until stall drops)
core_we_i  input  1  1 = store, 0 = load
core_size_i  input  3  funct3: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU (stores use 0/1/2)
core_addr_i  input  32  byte address
core_wd_i  input  32  store data, right-justified
core_rd_o  output  32  extended load data, valid while state is DONE
core_stall_o  output  1  stall to core (feeds the core's stall_i)
lsu_err_o  output  1  1-cycle pulse in DONE on an aborted access
lsu_err_code_o  output  2  0 none, 1 misaligned, 2 illegal size, 3 timeout
mem_req_o  output  1  memory request, registered
mem_we_o  output  1  memory write enable, registered
mem_be_o  output  4  byte enables, registered
mem_addr_o  output  32  {addr[31:2],2'b00}, registered
mem_wd_o  output  32  lane-replicated write data, registered
mem_rd_i  input  32  memory read word, valid when mem_ready_i=1
mem_ready_i  input  1  memory accepts/completes the current request this cycle

Behaviour:
- Reset (synchronous, rst_i=1 at a rising edge):
  - state=IDLE.
  - mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wd_o=0.
  - core_rd_o=0, lsu_err_o=0, lsu_err_code_o=0, timeout counter=0.
  - Reset mid-access abandons the access: mem_req_o is 0 after that edge and no DONE is produced.
- core_stall_o = core_req_i && state!=DONE (combinational). It is 0 whenever core_req_i=0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - If core_req_i=0, stay in IDLE.
  - If core_req_i=1, check the size and alignment:
    - Illegal size: any store size >2, or a load size of 3, 6 or 7.
    - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
    - Illegal size takes priority over misaligned.
  - On an error: go to DONE with the error code registered, core_rd_o=0, and no memory request.
  - Otherwise: register the mem_* outputs, set mem_req_o=1 and go to BUSY.
- Byte enables and write data:
  - Byte: be = 4'b0001 << addr[1:0]; wd = {4{wd[7:0]}}.
  - Half: be = 4'b0011 << {addr[1],1'b0}; wd = {2{wd[15:0]}}.
  - Word: be = 4'b1111; wd = wd.
  - Loads drive the same be pattern, with mem_we_o=0.
- BUSY:
  - mem_* outputs are held stable until mem_ready_i=1.
  - Counter increments every cycle that mem_ready_i=0.
  - mem_ready_i=1:
    - For a load, register the extracted lane of mem_rd_i:
      - LB / LH: sign-extend.
      - LBU / LHU: zero-extend.
      - LW: pass through.
      - Byte lane = addr[1:0]; half lane = addr[1].
    - For a store, core_rd_o=0.
    - Then mem_req_o=0, go to DONE.
  - Counter reaches TIMEOUT_CYCLES with mem_ready_i=0: mem_req_o=0, code=3, core_rd_o=0, go to DONE.
  - mem_ready_i=1 in the same cycle as the timeout hit: the completion wins, with no error.
- DONE:
  - Stall is low for exactly this cycle, so the core commits on the edge that ends DONE.
  - lsu_err_o is 1 iff code!=0.
  - Next state is IDLE; counter and code are cleared.
  - core_rd_o is held until the next access completes.
- Back-to-back accesses: the core's next request is seen in IDLE one cycle after DONE; there is no overlap of accesses.
- Latency with zero-wait memory (mem_ready_i=1 on the first BUSY cycle):
  - Request seen at cycle T.
  - BUSY at T+1.
  - DONE at T+2.
  - The core is stalled for 2 cycles.
- Each wait cycle adds 1 to the latency.
- mem_ready_i outside BUSY is ignored.

Test Plan:
- LW: addr 0x100, mem_rd_i=0xDEADBEEF, ready on the first BUSY cycle -> mem_addr_o=0x100, mem_be_o=1111, stall high 2 cycles, core_rd_o=0xDEADBEEF in DONE.
- LB addr 0x103 and LBU addr 0x103, mem_rd_i=0x80FF_1234 -> be=1000; LB gives 0xFFFFFF80, LBU gives 0x00000080; LH addr 0x102 gives 0xFFFF80FF.
- SH addr 0x0A, wd=0x1234ABCD, ready after 3 wait cycles -> mem_addr_o=0x08, be=1100, mem_wd_o=0xABCDABCD, mem_we_o=1 stable across the waits, DONE at T+5.
- Misaligned LW at 0x102 and illegal size 3 -> no mem_req_o; DONE at T+1 with lsu_err_o=1 and code 1 or 2 respectively; core_rd_o=0.
- TIMEOUT_CYCLES=4, mem_ready_i held 0 -> mem_req_o drops after 4 BUSY cycles, code=3 pulse, core released; repeat with ready on the 4th cycle -> no error.
- rst_i asserted during BUSY -> mem_req_o=0 and state IDLE after that edge, no DONE pulse; a following LW completes normally.
